// File: rtl/primary_ray_gen.sv
// Primary ray generator: raster-scans the screen and emits one ray per pixel, building directions
// incrementally from a latched camera. Define RAYGEN_FRAME_LOOP_EN to run frames back-to-back.
module primary_ray_gen #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int FIX_W    = 32,
    parameter int COORD_W  = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3*FIX_W-1:0]   cam_origin,
    input  logic [3*FIX_W-1:0]   cam_corner,
    input  logic [3*FIX_W-1:0]   cam_du,
    input  logic [3*FIX_W-1:0]   cam_dv,
    input  logic                 fifo_full,
    output logic                 add_input,
    output logic [3*FIX_W-1:0]   ray_origin,
    output logic [3*FIX_W-1:0]   ray_dir,
    output logic [COORD_W-1:0]   pixel_x,
    output logic [COORD_W-1:0]   pixel_y,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           frame_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(SCREEN_H - 1);

    // Per-component add; each lane wraps independently on overflow.
    function automatic logic [3*FIX_W-1:0] vec_add(input logic [3*FIX_W-1:0] a,
                                                   input logic [3*FIX_W-1:0] b);
        logic [3*FIX_W-1:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            r[k*FIX_W +: FIX_W] = a[k*FIX_W +: FIX_W] + b[k*FIX_W +: FIX_W];
        end
        return r;
    endfunction

    state_t               r_state;
    state_t               w_next_state;
    logic [3*FIX_W-1:0]   r_origin;
    logic [3*FIX_W-1:0]   r_du;
    logic [3*FIX_W-1:0]   r_dv;
    logic [3*FIX_W-1:0]   r_row_base;
    logic [3*FIX_W-1:0]   r_dir;
    logic [COORD_W-1:0]   r_px;
    logic [COORD_W-1:0]   r_py;
    logic [7:0]           r_frame_count;

    logic                 w_issue;
    logic                 w_last_col;
    logic                 w_last_pix;
    logic [3*FIX_W-1:0]   w_next_row;
    logic [3*FIX_W-1:0]   w_next_dir;

    assign w_issue    = (r_state == S_EMIT) && !fifo_full;
    assign w_last_col = (r_px == LAST_X);
    assign w_last_pix = w_last_col && (r_py == LAST_Y);
    assign w_next_row = vec_add(r_row_base, r_dv);
    assign w_next_dir = vec_add(r_dir, r_du);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_EMIT;
            S_EMIT: if (w_issue && w_last_pix) w_next_state = S_DONE;
            S_DONE: begin
`ifdef RAYGEN_FRAME_LOOP_EN
                w_next_state = S_LOAD;
`else
                w_next_state = S_IDLE;
`endif
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_origin      <= '0;
            r_du          <= '0;
            r_dv          <= '0;
            r_row_base    <= '0;
            r_dir         <= '0;
            r_px          <= '0;
            r_py          <= '0;
            r_frame_count <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_LOAD: begin
                    r_origin   <= cam_origin;
                    r_du       <= cam_du;
                    r_dv       <= cam_dv;
                    r_row_base <= cam_corner;
                    r_dir      <= cam_corner;
                    r_px       <= '0;
                    r_py       <= '0;
                end
                S_EMIT: begin
                    // The final pixel leaves the fields holding its values.
                    if (w_issue && !w_last_pix) begin
                        if (!w_last_col) begin
                            r_px  <= r_px + COORD_W'(1);
                            r_dir <= w_next_dir;
                        end else begin
                            r_px       <= '0;
                            r_py       <= r_py + COORD_W'(1);
                            r_row_base <= w_next_row;
                            r_dir      <= w_next_row;
                        end
                    end
                end
                S_DONE: r_frame_count <= r_frame_count + 8'd1;
                default: ;
            endcase
        end
    end

    assign add_input   = w_issue;
    assign ray_origin  = r_origin;
    assign ray_dir     = r_dir;
    assign pixel_x     = r_px;
    assign pixel_y     = r_py;
    assign busy        = (r_state == S_LOAD) || (r_state == S_EMIT);
    assign frame_done  = (r_state == S_DONE);
    assign frame_count = r_frame_count;

endmodule
